// File: rtl/dpram_pkg.sv
// Shared types and helpers for the pipelined dual-port RAM (dpram_pipe).
// Optional parity storage is enabled by defining DPRAM_PARITY_EN.
package dpram_pkg;

  localparam int MAX_READ_LAT = 2;

  typedef enum logic [1:0] {
    RST,
    CLEAR,
    RUN
  } fsm_state_e;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/dpram_read_pipe.sv
// Per-port read path: registered word, write-first byte merge, optional parity
// check (DPRAM_PARITY_EN) and an optional second output register.
module dpram_read_pipe
  import dpram_pkg::*;
#(
  parameter int DW       = 64,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [DW-1:0]     mem_word,
`ifdef DPRAM_PARITY_EN
  input  logic [DW/8-1:0]   mem_par,
`endif
  input  logic [DW/8-1:0]   fwd_mask,
  input  logic [DW-1:0]     fwd_data,
  output logic [DW-1:0]     rdata,
  output logic              valid,
  output logic              perr
);

  localparam int NB  = DW / 8;
  localparam int LAT = (READ_LAT >= MAX_READ_LAT) ? MAX_READ_LAT : 1;

  logic          s1_valid;
  logic [DW-1:0] s1_word;
  logic [DW-1:0] s1_fwd;
  logic [NB-1:0] s1_mask;
  logic [DW-1:0] s1_data;
  logic          s1_perr;

  // Stage registers only load on an accepted request, so the merged output
  // holds its last value between requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
      s1_fwd   <= '0;
      s1_mask  <= '0;
    end else begin
      s1_valid <= req;
      if (req) begin
        s1_word <= mem_word;
        s1_fwd  <= fwd_data;
        s1_mask <= fwd_mask;
      end
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    s1_data = s1_word;
    for (int i = 0; i < NB; i++) begin
      if (s1_mask[i]) s1_data[8*i +: 8] = s1_fwd[8*i +: 8];
    end
  end

`ifdef DPRAM_PARITY_EN
  logic [NB-1:0] s1_par;
  logic [NB-1:0] s1_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   s1_par <= '0;
    else if (req) s1_par <= mem_par;
  end

  // Forwarded bytes come straight from the write data and are never flagged.
  always_comb begin
    s1_bad = '0;
    for (int i = 0; i < NB; i++) begin
      s1_bad[i] = (byte_parity(s1_word[8*i +: 8]) != s1_par[i]) && !s1_mask[i];
    end
  end

  assign s1_perr = s1_valid && (|s1_bad);
`else
  assign s1_perr = 1'b0;
`endif

  generate
    if (LAT == 1) begin : g_lat1
      assign rdata = s1_data;
      assign valid = s1_valid;
      assign perr  = s1_perr;
    end else begin : g_lat2
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata <= '0;
          valid <= 1'b0;
          perr  <= 1'b0;
        end else begin
          valid <= s1_valid;
          perr  <= s1_perr;
          if (s1_valid) rdata <= s1_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/dpram_pipe.sv
// Single-clock dual-port RAM: port A read-only, port B byte-enable read/write,
// write-first forwarding, post-reset clear sequencer. Parity: DPRAM_PARITY_EN.
module dpram_pipe
  import dpram_pkg::*;
#(
  parameter int DW             = 64,
  parameter int DEPTH          = 16384,
  parameter int AW             = $clog2(DEPTH),
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_en,
  input  logic [AW-1:0]   a_addr,
  output logic [DW-1:0]   a_rdata,
  output logic            a_valid,
  input  logic            b_en,
  input  logic            b_re,
  input  logic [DW/8-1:0] b_we,
  input  logic [AW-1:0]   b_addr,
  input  logic [DW-1:0]   b_wdata,
  output logic [DW-1:0]   b_rdata,
  output logic            b_valid,
  output logic            init_done,
  output logic            a_perr,
  output logic            b_perr
);

  localparam int NB = DW / 8;

  fsm_state_e    state;
  logic [AW-1:0] clr_addr;
  logic [NB-1:0] run_be;
  logic [NB-1:0] a_fwd;
  logic [NB-1:0] wr_be;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] mem [DEPTH];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RST;
      clr_addr  <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        RST: begin
          clr_addr <= '0;
          if (CLEAR_ON_RESET != 0) begin
            state <= CLEAR;
          end else begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        CLEAR: begin
          clr_addr <= clr_addr + AW'(1);
          if (clr_addr == AW'(DEPTH - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN:     ;
        default: state <= RST;
      endcase
    end
  end

  // Requests outside RUN are dropped: no write, no forward, no valid.
  assign run_be = (init_done && b_en) ? b_we : '0;
  assign a_fwd  = (b_addr == a_addr) ? run_be : '0;

  always_comb begin
    wr_be   = run_be;
    wr_addr = b_addr;
    wr_data = b_wdata;
    if (state == CLEAR) begin
      wr_be   = '1;
      wr_addr = clr_addr;
      wr_data = '0;
    end
  end

  // NOTE: the array has no reset; contents survive rst_n and the storage can map onto block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

`ifdef DPRAM_PARITY_EN
  logic [NB-1:0] par [DEPTH];

  // Clear writes zero data, whose even parity is 0.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) par[wr_addr][i] <= byte_parity(wr_data[8*i +: 8]);
    end
  end
`endif

  dpram_read_pipe #(
    .DW       (DW),
    .READ_LAT (READ_LAT)
  ) u_a_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (init_done && a_en),
    .mem_word (mem[a_addr]),
`ifdef DPRAM_PARITY_EN
    .mem_par  (par[a_addr]),
`endif
    .fwd_mask (a_fwd),
    .fwd_data (b_wdata),
    .rdata    (a_rdata),
    .valid    (a_valid),
    .perr     (a_perr)
  );

  dpram_read_pipe #(
    .DW       (DW),
    .READ_LAT (READ_LAT)
  ) u_b_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (init_done && b_en && b_re),
    .mem_word (mem[b_addr]),
`ifdef DPRAM_PARITY_EN
    .mem_par  (par[b_addr]),
`endif
    .fwd_mask (run_be),
    .fwd_data (b_wdata),
    .rdata    (b_rdata),
    .valid    (b_valid),
    .perr     (b_perr)
  );

endmodule

// File: tb/tb_dpram_pipe.sv
// Directed bench for dpram_pipe: READ_LAT=1 and READ_LAT=2 instances share stimulus,
// DEPTH=16 with clear-on-reset. Parity cases compile only with DPRAM_PARITY_EN.
module tb_dpram_pipe;

  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int NB    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          a_en, b_en, b_re;
  logic [AW-1:0] a_addr, b_addr;
  logic [NB-1:0] b_we;
  logic [DW-1:0] b_wdata;
  logic [DW-1:0] a_rdata [2];
  logic [DW-1:0] b_rdata [2];
  logic          a_valid [2];
  logic          b_valid [2];
  logic          init_done [2];
  logic          a_perr [2];
  logic          b_perr [2];

  dpram_pipe #(.DW(DW), .DEPTH(DEPTH), .READ_LAT(1), .CLEAR_ON_RESET(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_addr(a_addr), .a_rdata(a_rdata[0]), .a_valid(a_valid[0]),
    .b_en(b_en), .b_re(b_re), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata[0]), .b_valid(b_valid[0]), .init_done(init_done[0]),
    .a_perr(a_perr[0]), .b_perr(b_perr[0])
  );

  dpram_pipe #(.DW(DW), .DEPTH(DEPTH), .READ_LAT(2), .CLEAR_ON_RESET(1)) u_lat2 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_addr(a_addr), .a_rdata(a_rdata[1]), .a_valid(a_valid[1]),
    .b_en(b_en), .b_re(b_re), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata[1]), .b_valid(b_valid[1]), .init_done(init_done[1]),
    .a_perr(a_perr[1]), .b_perr(b_perr[1])
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          perr;
    int            cyc;
  } exp_t;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc   = 0;
  exp_t          q [4][$];
  logic [DW-1:0] mdl [DEPTH];
  logic [NB-1:0] bad [DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [NB-1:0] be);
    merge = old;
    for (int i = 0; i < NB; i++) if (be[i]) merge[8*i +: 8] = nw[8*i +: 8];
  endfunction

  // Index k = instance*2 + port (port 0 = A, 1 = B).
  task automatic mon(input int k, input logic v, input logic [DW-1:0] d, input logic p);
    exp_t  e;
    string nm;
    nm = $sformatf("lat%0d_%s", k / 2 + 1, (k % 2) ? "b" : "a");
    if (!v) return;
    if (q[k].size() == 0) begin
      check({nm, "_spurious_valid"}, 64'(v), 64'(0));
      return;
    end
    e = q[k].pop_front();
    check({nm, "_latency"}, 64'(cyc), 64'(e.cyc));
    check({nm, "_data"}, d, e.data);
    check({nm, "_perr"}, 64'(p), 64'(e.perr));
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      mon(i * 2,     a_valid[i], a_rdata[i], a_perr[i]);
      mon(i * 2 + 1, b_valid[i], b_rdata[i], b_perr[i]);
    end
  end

  task automatic set_idle();
    a_en = 1'b0; a_addr = '0;
    b_en = 1'b0; b_re = 1'b0; b_we = '0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic expect_rd(input int port, input logic [DW-1:0] d, input logic p);
    exp_t e;
    e.data = d;
    e.perr = p;
    for (int i = 0; i < 2; i++) begin
      e.cyc = cyc + i + 1;
      q[i * 2 + port].push_back(e);
    end
  endtask

  // One request cycle; called at posedge+1, returns at the next posedge+1.
  task automatic drive(input logic ae, input logic [AW-1:0] aa, input logic be, input logic bre,
                       input logic [NB-1:0] bwe, input logic [AW-1:0] ba, input logic [DW-1:0] bwd);
    logic [NB-1:0] amask;
    a_en = ae; a_addr = aa; b_en = be; b_re = bre; b_we = bwe; b_addr = ba; b_wdata = bwd;
    amask = (be && ba == aa) ? bwe : '0;
    if (ae) expect_rd(0, merge(mdl[aa], bwd, amask), |(bad[aa] & ~amask));
    if (be && bre) expect_rd(1, merge(mdl[ba], bwd, bwe), |(bad[ba] & ~bwe));
    if (be) begin
      mdl[ba] = merge(mdl[ba], bwd, bwe);
      bad[ba] = bad[ba] & ~bwe;
    end
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic rd_a(input logic [AW-1:0] a);
    drive(1'b1, a, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic rd_b(input logic [AW-1:0] a);
    drive(1'b0, '0, 1'b1, 1'b1, '0, a, '0);
  endtask

  task automatic wr_b(input logic [AW-1:0] a, input logic [NB-1:0] we, input logic [DW-1:0] d);
    drive(1'b0, '0, 1'b1, 1'b0, we, a, d);
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) check($sformatf("pending_q%0d", k), 64'(q[k].size()), 64'(0));
  endtask

  task automatic check_reset(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_flags%0d", tag, i),
            64'({a_valid[i], b_valid[i], init_done[i], a_perr[i], b_perr[i]}), 64'(0));
      check($sformatf("%s_a_rdata%0d", tag, i), a_rdata[i], '0);
      check($sformatf("%s_b_rdata%0d", tag, i), b_rdata[i], '0);
    end
  endtask

  // Holds requests (including a full write to addr 0) active while the block is
  // not ready; all must be dropped. init_done must rise on edge DEPTH+1.
  task automatic release_and_wait(input string tag);
    int rise [2];
    int n;
    rise[0] = 0; rise[1] = 0; n = 0;
    a_en = 1'b1; a_addr = '0;
    b_en = 1'b1; b_re = 1'b1; b_we = '1; b_addr = '0; b_wdata = '1;
    @(negedge clk);
    rst_n = 1'b1;
    while ((rise[0] == 0 || rise[1] == 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
      for (int i = 0; i < 2; i++) if (init_done[i] && rise[i] == 0) rise[i] = n;
    end
    set_idle();
    for (int i = 0; i < 2; i++) check($sformatf("%s_init_cycle%0d", tag, i), 64'(rise[i]), 64'(DEPTH + 1));
    for (int i = 0; i < DEPTH; i++) begin
      mdl[i] = '0;
      bad[i] = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    set_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_reset("reset");

    release_and_wait("first_init");

    // Cleared contents, back-to-back on port A, a couple on port B.
    for (int a = 0; a < DEPTH; a++) rd_a(AW'(a));
    rd_b(4'd0);
    rd_b(4'd15);

    // Partial byte write over all-ones.
    wr_b(4'd5, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wr_b(4'd5, 8'h0F, 64'h1122_3344_5566_7788);
    rd_a(4'd5);
    rd_b(4'd5);

    // Port A read collides with port B write of low byte.
    drive(1'b1, 4'd3, 1'b1, 1'b0, 8'h01, 4'd3, 64'h0000_0000_0000_00A5);
    // Port B read-with-write on the same word returns the merged word.
    drive(1'b0, 4'd0, 1'b1, 1'b1, 8'hF0, 4'd5, 64'hAABB_CCDD_0000_0000);
    rd_a(4'd5);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      check($sformatf("hold_a_rdata%0d", i), a_rdata[i], 64'hAABB_CCDD_5566_7788);

    // Back-to-back stream 0..3.
    for (int a = 0; a < 4; a++) rd_a(AW'(a));

    // Write in the cycle after a read is not forwarded to that read.
    rd_a(4'd3);
    wr_b(4'd3, 8'hFF, 64'h0000_0000_0000_0123);
    rd_a(4'd3);

    // b_we without b_en neither writes nor forwards; b_en with no we/re is a no-op.
    drive(1'b1, 4'd3, 1'b0, 1'b0, 8'hFF, 4'd3, 64'hDEAD_BEEF_DEAD_BEEF);
    drive(1'b0, 4'd0, 1'b1, 1'b0, 8'h00, 4'd3, 64'hDEAD_BEEF_DEAD_BEEF);
    rd_b(4'd3);
    rd_a(4'd3);

`ifdef DPRAM_PARITY_EN
    u_lat1.par[7][0] = ~u_lat1.par[7][0];
    u_lat2.par[7][0] = ~u_lat2.par[7][0];
    bad[7] = 8'h01;
    rd_b(4'd7);
    rd_b(4'd6);
    drive(1'b1, 4'd7, 1'b1, 1'b1, 8'h01, 4'd7, 64'h0000_0000_0000_0077);
    rd_b(4'd7);
`endif

    drain();

    // Asynchronous reset from RUN, asserted mid-cycle.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");

    // Abort the sweep with the clear counter at address 8, then restart it.
    @(negedge clk);
    rst_n = 1'b1;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("mid_clear_rst");
    release_and_wait("after_abort");

    rd_a(4'd0);
    rd_a(4'd3);
    rd_b(4'd5);
    rd_b(4'd15);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dpram_pipe.md
Name: dpram_pipe

Overview:
- Parametrised single-clock dual-port block RAM with a pipelined read path.
- Port A is read-only (instruction fetch). Port B is read/write with byte enables (load/store).
- Adds what the core memory path lacks: generic width and depth, 1- or 2-cycle read latency, same-cycle write-to-read forwarding, and a post-reset clear sequencer with an init_done handshake.
- Sits between the core fetch/LSU and the on-chip program memory.

Parameters:
- DW, 64, data width in bits; must be a multiple of 8.
- DEPTH, 16384, number of words; power of two.
- AW, $clog2(DEPTH), address width (derived; do not override).
- READ_LAT, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register).
- CLEAR_ON_RESET, 0, when 1 the sequencer zeroes every word after reset release.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- a_en  in  1  port A read request.
- a_addr  in  AW  port A word address.
- a_rdata  out  DW  port A read data.
- a_valid  out  1  a_rdata valid (one-cycle pulse per request).
- b_en  in  1  port B enable.
- b_re  in  1  port B read request; qualified by b_en.
- b_we  in  DW/8  port B byte write enables; qualified by b_en.
- b_addr  in  AW  port B word address.
- b_wdata  in  DW  port B write data.
- b_rdata  out  DW  port B read data.
- b_valid  out  1  b_rdata valid.
- init_done  out  1  block accepts requests.
- a_perr  out  1  port A parity error (see Optional Feature).
- b_perr  out  1  port B parity error (see Optional Feature).

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0: a_valid, b_valid, a_perr, b_perr and init_done are 0; a_rdata and b_rdata are 0; FSM is in RST; the read pipeline is flushed.
- Memory contents are not reset by rst_n.
- FSM states: RST -> (CLEAR if CLEAR_ON_RESET else RUN) on the first clk after rst_n rises.
- CLEAR: a counter walks addresses 0..DEPTH-1, writing one zero word per cycle. At DEPTH-1 the FSM moves to RUN.
- RUN: init_done=1. Entry to RUN is 1 cycle after reset release, or DEPTH+1 cycles when clearing.
- Requests while init_done=0 are dropped silently. They produce no valid and perform no write.
- Reset asserted mid-CLEAR aborts the sweep. The sweep restarts from address 0 after release.
- Read latency:
  - Request accepted at cycle N (a_en=1, or b_en&b_re=1) -> valid and data at cycle N+READ_LAT.
  - Valid is high for exactly one cycle per accepted request.
  - Back-to-back requests are accepted every cycle; no stall and no ready signal.
- Data outputs hold their last value when valid=0.
- Writes: when b_en=1, each byte i with b_we[i]=1 is written from b_wdata[8i+:8] at the clock edge. Writes take effect immediately. b_we=0 together with b_re=0 is a no-op.
- Collisions use write-first semantics on both ports:
  - Port B read with write, same address and same cycle: b_rdata returns the merged word (new bytes where b_we=1, old bytes elsewhere).
  - Port A read at the address port B writes in the same cycle: a_rdata returns the same merged word.
  - Both are implemented with a bypass mux and a registered byte mask, not by relying on primitive collision behaviour.
- Address is truncated to AW bits; there is no out-of-range detection.
- With READ_LAT=2, a write to the same address issued in cycle N+1 is not forwarded to a read accepted in cycle N. The read returns cycle-N data.

Optional Feature:
- Macro DPRAM_PARITY_EN.
- Defined:
  - Each byte stores an extra even-parity bit, computed on write (CLEAR writes parity 0).
  - On read, parity is rechecked. a_perr/b_perr assert together with the corresponding valid when any byte mismatches.
  - Forwarded bytes are always correct.
- Undefined: there is no parity storage, and a_perr/b_perr are tied 0.

Decomposition:
- Package dpram_pkg holds:
  - typedef enum fsm_state_e {RST, CLEAR, RUN};
  - function byte_parity();
  - localparam MAX_READ_LAT=2.
- Sub-module dpram_read_pipe: one per port. It holds the valid/data delay line, the forward-merge mux and the optional parity check, parametrised by DW and READ_LAT.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH=16: release reset -> init_done rises at cycle 17; a read of every address returns 0.
- Write b_addr=5, b_we=8'h0F, b_wdata=64'h1122334455667788 over prior 0xFF.. contents -> a later read of 5 returns 64'hFFFFFFFF55667788.
- Same cycle: port B writes addr 3 = 64'hA5 (b_we=8'h01); port A reads addr 3 -> a_rdata low byte A5 with a_valid at N+READ_LAT.
- READ_LAT=2: 4 back-to-back port A reads of addrs 0..3 -> 4 consecutive valid pulses starting at N+2, data in order.
- Assert rst_n mid-CLEAR at address 8 -> outputs drop to 0 asynchronously; after release, init_done waits a full DEPTH+1 cycles.
- DPRAM_PARITY_EN: force-flip one stored bit at addr 7 and read it -> b_perr=1 with b_valid; a clean address gives b_perr=0.
